// File: rtl/excp_commit_pkg.sv
// rtl/excp_commit_pkg.sv - shared exception cause type, interrupt code and FSM states
package excp_commit_pkg;

    typedef struct packed {
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } exception_t;

    localparam exception_t ECODE_INT = '{ecode: 6'd0, esubcode: 9'd0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_FLUSH,
        ST_REDIRECT
    } state_e;

endpackage

// File: rtl/excp_commit_prio.sv
// rtl/excp_commit_prio.sv - trap priority select: interrupt > exception > ertn
module excp_prio
    import excp_commit_pkg::*;
(
    input  logic       interrupt,
    input  logic       commit_excp,
    input  exception_t commit_excp_type,
    input  logic       commit_ertn,
    output logic       take_trap,
    output exception_t cause,
    output logic       is_ertn
);

    always_comb begin
        take_trap = interrupt | commit_excp | commit_ertn;
        cause     = '0;
        is_ertn   = 1'b0;
        if (interrupt) begin
            cause = ECODE_INT;
        end else if (commit_excp) begin
            cause = commit_excp_type;
        end else begin
            is_ertn = commit_ertn;
        end
    end

endmodule

// File: rtl/excp_commit.sv
// rtl/excp_commit.sv - commit-stage trap sequencer; EXCP_BADV_EN enables BADV capture
module excp_commit
    import excp_commit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_excp,
    input  exception_t  commit_excp_type,
    input  logic        commit_ertn,
    input  logic        commit_badv_valid,
    input  logic [31:0] commit_badv,
    input  logic        interrupt,
    input  logic [31:0] csr_pc,
    output logic        have_exception,
    output exception_t  exception_type,
    output logic        ertn,
    output logic [31:0] pc_in,
    output logic        badv_we,
    output logic [31:0] badv_data,
    output logic        flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc
);

    state_e      state_q;
    logic        commit_ready_q, have_exception_q, ertn_q, flush_q, redirect_valid_q;
    exception_t  exception_type_q;
    logic [31:0] pc_q, redirect_pc_q;
    logic [3:0]  cnt_q;

    logic        take_trap, is_ertn, accept;
    exception_t  cause;

    excp_prio u_prio (
        .interrupt        (interrupt),
        .commit_excp      (commit_excp),
        .commit_excp_type (commit_excp_type),
        .commit_ertn      (commit_ertn),
        .take_trap        (take_trap),
        .cause            (cause),
        .is_ertn          (is_ertn)
    );

    // Ready is registered, so the first cycle after reset release accepts nothing.
    assign accept = (state_q == ST_IDLE) && commit_ready_q && commit_valid && take_trap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            commit_ready_q   <= 1'b0;
            have_exception_q <= 1'b0;
            exception_type_q <= '0;
            ertn_q           <= 1'b0;
            pc_q             <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            cnt_q            <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    commit_ready_q <= 1'b1;
                    if (accept) begin
                        state_q          <= ST_TRAP;
                        commit_ready_q   <= 1'b0;
                        have_exception_q <= 1'b1;
                        exception_type_q <= cause;
                        ertn_q           <= is_ertn;
                        pc_q             <= commit_pc;
                        flush_q          <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    have_exception_q <= 1'b0;
                    exception_type_q <= '0;
                    ertn_q           <= 1'b0;
                    pc_q             <= '0;
                    redirect_pc_q    <= csr_pc;
                    cnt_q            <= 4'(FLUSH_CYCLES);
                    if (FLUSH_CYCLES == 0) begin
                        state_q          <= ST_REDIRECT;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        state_q          <= ST_REDIRECT;
                        cnt_q            <= '0;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_q          <= ST_IDLE;
                        redirect_valid_q <= 1'b0;
                        commit_ready_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef EXCP_BADV_EN
    logic        badv_we_q;
    logic [31:0] badv_data_q;
    logic        excp_trap;

    // Only genuine exceptions carry a faulting address; interrupts and ERTN never write BADV.
    assign excp_trap = commit_excp && !interrupt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            badv_we_q   <= 1'b0;
            badv_data_q <= '0;
        end else if (accept) begin
            badv_we_q   <= excp_trap && commit_badv_valid;
            badv_data_q <= excp_trap ? commit_badv : 32'd0;
        end else if (state_q == ST_TRAP) begin
            badv_we_q   <= 1'b0;
            badv_data_q <= '0;
        end
    end

    assign badv_we   = badv_we_q;
    assign badv_data = badv_data_q;
`else
    logic unused_badv;
    assign unused_badv = ^{commit_badv_valid, commit_badv};
    assign badv_we     = 1'b0;
    assign badv_data   = '0;
`endif

    assign commit_ready   = commit_ready_q;
    assign have_exception = have_exception_q;
    assign exception_type = exception_type_q;
    assign ertn           = ertn_q;
    assign pc_in          = pc_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_excp_commit.sv
// tb/tb_excp_commit.sv - scoreboard bench for excp_commit with randomized commits
module tb_excp_commit;
    import excp_commit_pkg::*;

    localparam int FC = 2;
`ifdef EXCP_BADV_EN
    localparam bit BADV_EN = 1'b1;
`else
    localparam bit BADV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid, commit_ready, commit_excp, commit_ertn;
    logic [31:0] commit_pc, commit_badv, csr_pc, pc_in, badv_data, redirect_pc;
    exception_t  commit_excp_type, exception_type;
    logic        commit_badv_valid, interrupt, have_exception, ertn, badv_we;
    logic        flush, redirect_valid, redirect_ready;

    excp_commit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_excp(commit_excp),
        .commit_excp_type(commit_excp_type), .commit_ertn(commit_ertn),
        .commit_badv_valid(commit_badv_valid), .commit_badv(commit_badv),
        .interrupt(interrupt), .csr_pc(csr_pc),
        .have_exception(have_exception), .exception_type(exception_type),
        .ertn(ertn), .pc_in(pc_in), .badv_we(badv_we), .badv_data(badv_data),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] typ;
        logic        ertn;
        logic [31:0] pc;
        logic        bwe;
        logic [31:0] bdata;
        logic [31:0] rpc;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;
    int   traps_exp = 0, traps_done = 0, last_rv_cnt = 0;
    int   rr_hold = 0;
    bit   rr_directed = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Reference: what the CSR file should see for one commit presented in IDLE.
    function automatic bit model(input bit v, input bit i, input bit e, input logic [14:0] t,
                                 input bit r, input logic [31:0] pc, input bit bv,
                                 input logic [31:0] b, input logic [31:0] cp, output exp_t x);
        x = '{typ: '0, ertn: 1'b0, pc: '0, bwe: 1'b0, bdata: '0, rpc: '0};
        if (!v || !(i || e || r)) return 1'b0;
        x.pc  = pc;
        x.rpc = cp;
        if (i) begin
            x.typ = 15'd0;
        end else if (e) begin
            x.typ   = t;
            x.bwe   = BADV_EN && bv;
            x.bdata = BADV_EN ? b : 32'd0;
        end else begin
            x.ertn = 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic garbage();
        commit_valid      = 1'b1;
        interrupt         = 1'($urandom_range(0, 1));
        commit_excp       = 1'($urandom_range(0, 1));
        commit_ertn       = 1'($urandom_range(0, 1));
        commit_excp_type  = 15'($urandom);
        commit_pc         = $urandom;
        commit_badv_valid = 1'b1;
        commit_badv       = $urandom;
    endtask

    task automatic issue(input bit v, input bit i, input bit e, input logic [14:0] t,
                         input bit r, input logic [31:0] pc, input bit bv,
                         input logic [31:0] b, input logic [31:0] cp);
        exp_t x;
        bit   trap;
        int   n = 0;
        while (commit_ready !== 1'b1 && n < 300) begin
            garbage();
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("ready_wait");
        commit_valid = v; interrupt = i; commit_excp = e; commit_excp_type = t;
        commit_ertn = r; commit_pc = pc; commit_badv_valid = bv; commit_badv = b;
        csr_pc = cp;
        trap = model(v, i, e, t, r, pc, bv, b, cp, x);
        if (trap) begin
            q.push_back(x);
            traps_exp++;
        end
        @(negedge clk);
        chk("ready_after_commit", {31'd0, commit_ready}, {31'd0, !trap});
        if (!trap) chk("flush_after_normal", {31'd0, flush}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || traps_done != traps_exp || commit_ready !== 1'b1) && n < 500) begin
            if (commit_ready === 1'b1) commit_valid = 1'b0;
            else garbage();
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("drain");
        commit_valid = 1'b0;
    endtask

    initial begin
        redirect_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rr_hold > 0) begin
                redirect_ready = 1'b0;
                if (redirect_valid) rr_hold--;
            end else begin
                redirect_ready = rr_directed ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: trap pulses are matched against the scoreboard, then flush and redirect are tracked.
    initial begin
        exp_t cur;
        int   flush_cnt = 0;
        int   rv_cnt = 0;
        cur = '{typ: '0, ertn: 1'b0, pc: '0, bwe: 1'b0, bdata: '0, rpc: '0};
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                flush_cnt = 0;
                rv_cnt = 0;
            end else begin
                if (have_exception) begin
                    if (q.size() == 0) begin
                        chk("unexpected_trap", {31'd0, have_exception}, 32'd0);
                    end else begin
                        cur = q.pop_front();
                        chk("exception_type", {17'd0, exception_type}, {17'd0, cur.typ});
                        chk("ertn", {31'd0, ertn}, {31'd0, cur.ertn});
                        chk("pc_in", pc_in, cur.pc);
                        chk("badv_we", {31'd0, badv_we}, {31'd0, cur.bwe});
                        chk("badv_data", badv_data, cur.bdata);
                    end
                end else begin
                    chk("badv_we_outside_trap", {31'd0, badv_we}, 32'd0);
                end
                if (flush) begin
                    flush_cnt++;
                end else if (flush_cnt != 0) begin
                    chk("flush_len", flush_cnt, FC + 1);
                    flush_cnt = 0;
                end
                if (redirect_valid) begin
                    chk("flush_during_redirect", {31'd0, flush}, 32'd0);
                    chk("redirect_pc", redirect_pc, cur.rpc);
                    rv_cnt++;
                    if (redirect_ready) begin
                        last_rv_cnt = rv_cnt;
                        rv_cnt = 0;
                        traps_done++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b0;
        commit_valid = 1'b0; interrupt = 1'b0; commit_excp = 1'b0; commit_ertn = 1'b0;
        commit_excp_type = '0; commit_pc = '0; commit_badv_valid = 1'b0; commit_badv = '0;
        csr_pc = '0;
        #1;
        chk("reset_ready", {31'd0, commit_ready}, 32'd0);
        chk("reset_outputs", {29'd0, have_exception, flush, redirect_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, commit_ready}, 32'd1);

        issue(1, 0, 0, 15'h0000, 0, 32'h1c000000, 0, 32'h0, 32'h1c008000);
        issue(1, 0, 1, 15'h0400, 0, 32'h1c000010, 1, 32'hdeadbeef, 32'h1c008000);
        drain();
        issue(1, 1, 0, 15'h7fff, 1, 32'h1c000020, 1, 32'h12345678, 32'h1c008000);
        drain();
        issue(0, 1, 1, 15'h0400, 1, 32'h1c000030, 1, 32'h0, 32'h1c008000);
        issue(1, 0, 1, 15'h0c05, 1, 32'h1c000040, 0, 32'h55aa55aa, 32'h1c00a000);
        drain();
        rr_hold = 5;
        issue(1, 0, 0, 15'h0000, 1, 32'h1c000050, 0, 32'h0, 32'h1c000100);
        drain();
        chk("redirect_hold_cycles", last_rv_cnt, 6);

        rr_directed = 1'b0;
        for (int k = 0; k < 60; k++) begin
            issue(($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) < 4), 15'($urandom), ($urandom_range(0, 9) < 3),
                  $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        drain();
        rr_directed = 1'b1;

        issue(1, 0, 1, 15'h0400, 0, 32'h1c000060, 1, 32'hdeadbeef, 32'h1c008000);
        n = 0;
        while (!(flush && !have_exception) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("reach_flush");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_mid_flush_ready", {31'd0, commit_ready}, 32'd0);
        chk("reset_mid_flush_ctl", {28'd0, have_exception, flush, redirect_valid, ertn}, 32'd0);
        chk("reset_mid_flush_badv", {31'd0, badv_we}, 32'd0);
        chk("reset_mid_flush_pc", redirect_pc, 32'd0);
        traps_exp--;
        commit_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rerelease", {31'd0, commit_ready}, 32'd1);
        chk("flush_after_rerelease", {31'd0, flush}, 32'd0);

        issue(1, 0, 1, 15'h0800, 0, 32'h1c000070, 1, 32'hcafef00d, 32'h1c009000);
        drain();

        chk("queue_empty", q.size(), 0);
        chk("traps_completed", traps_done, traps_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
